// File: rtl/bram_burst_reader_if.sv
// Bus bundle for the BRAM burst reader: command handshake, RAM read port,
// output stream and status. The reader uses the master view; the environment uses the slave view.
interface bram_burst_reader_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
        output cmd_ready, ram_en, ram_addr, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
        input  cmd_ready, ram_en, ram_addr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/bram_burst_reader.sv
// Burst reader for a 1-cycle-latency synchronous BRAM: issues reads under a
// 2-slot credit limit and streams bytes through a 2-entry FIFO with backpressure.
module bram_burst_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 12
) (
    input  logic                CLK,
    input  logic                reset_n,
    bram_burst_reader_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [LEN_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    inflight_q, inflight_d;
    logic [1:0][DATA_W-1:0]  fifo_q, fifo_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;
    logic                    pop_s;
    logic                    push_s;
    logic                    issue_s;

    // Handshake decode and read-issue credit: buffered + in flight after this pop must stay below 2.
    always_comb begin
        pop_s   = (count_q != 2'd0) && bus.out_ready;
        push_s  = inflight_q;
        issue_s = (state_q == ST_RUN) && (issue_cnt_q != '0) &&
                  (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));
    end

    // Next-state, address/counter and FIFO update.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        inflight_d  = issue_s;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d      = bus.cmd_addr;
                    issue_cnt_d = bus.cmd_len;
                    beat_cnt_d  = bus.cmd_len;
                    state_d     = (bus.cmd_len != '0) ? ST_RUN : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s) begin
                    addr_d      = addr_q + ADDR_W'(1);
                    issue_cnt_d = issue_cnt_q - LEN_W'(1);
                end else begin
                    issue_cnt_d = issue_cnt_q;
                end
                if (pop_s) begin
                    beat_cnt_d = beat_cnt_q - LEN_W'(1);
                    state_d    = (beat_cnt_q == LEN_W'(1)) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Read data lands one cycle after issue; the credit rule guarantees a free slot.
        if (push_s) begin
            fifo_d[wr_ptr_q] = bus.ram_dout;
            wr_ptr_d         = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            fifo_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= inflight_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Outputs decode straight from registers, except ram_en which must see this cycle's pop.
    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE);
        bus.ram_en    = issue_s;
        bus.ram_addr  = addr_q;
        bus.out_valid = (count_q != 2'd0);
        bus.out_data  = fifo_q[rd_ptr_q];
        bus.out_last  = (count_q != 2'd0) && (beat_cnt_q == LEN_W'(1));
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = (state_q == ST_DONE);
    end
endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader: a cycle table for a contiguous and a
// zero-length burst, then hand sequences for wrap, backpressure, back-to-back and reset.
module tb_bram_burst_reader;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    bram_burst_reader_if #(.ADDR_W(11), .DATA_W(8), .LEN_W(12)) bus ();

    bram_burst_reader #(.ADDR_W(11), .DATA_W(8), .LEN_W(12)) dut (
        .CLK     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [2048];
    always @(posedge clk) begin
        if (bus.ram_en) bus.ram_dout <= ram[bus.ram_addr];
    end

    function automatic logic [7:0] exp_byte(input logic [10:0] a);
        if (a >= 11'h010 && a <= 11'h013) return 8'hA0 + 8'(a - 11'h010);
        else                              return 8'(a * 11'd3) ^ 8'h5C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        cv;
        logic [10:0] ca;
        logic [11:0] cl;
        logic        rdy;
        logic        en;
        logic [10:0] ra;
        logic        ov;
        logic [7:0]  od;
        logic        ol;
        logic        dn;
        logic        bs;
        logic        cr;
    } vec_t;
    vec_t tbl [12];

    logic bp_patt [6];
    logic [10:0] sb_base;
    int   sb_len, n_issued, n_beats;
    logic prev_stall;
    logic [7:0] prev_data;

    // Per-cycle scoreboard: issue addresses, credit limit, beat order, last flag, stall stability.
    task automatic sample();
        logic pop;
        int   occ;
        pop = bus.out_valid && bus.out_ready;
        if (prev_stall) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, prev_data);
        end
        if (bus.ram_en) begin
            occ = n_issued - n_beats - (pop ? 1 : 0);
            chk("credit", occ < 2, 1);
            chk("over_issue", n_issued < sb_len, 1);
            chk("issue_addr", bus.ram_addr, 11'(sb_base + 11'(n_issued)));
            n_issued++;
        end
        if (pop) begin
            chk("over_beat", n_beats < sb_len, 1);
            chk("beat_data", bus.out_data, exp_byte(11'(sb_base + 11'(n_beats))));
            chk("beat_last", bus.out_last, n_beats == sb_len - 1);
            n_beats++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
    endtask

    task automatic sb_start(input logic [10:0] base, input int len);
        sb_base    = base;
        sb_len     = len;
        n_issued   = 0;
        n_beats    = 0;
        prev_stall = 1'b0;
    endtask

    task automatic drain(input int patt, input int start_cyc, output int done_cyc);
        done_cyc = -1;
        for (int c = start_cyc; c < start_cyc + 200; c++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            bus.out_ready = (patt == 0) ? 1'b1 : bp_patt[(c - 1) % 6];
            @(negedge clk);
            sample();
            if (bus.done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic run_burst(input logic [10:0] addr, input int len, input int patt, input int exp_done);
        int dc;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = 12'(len);
        bus.out_ready = 1'b1;
        sb_start(addr, len);
        @(negedge clk);
        chk("accept_ready", bus.cmd_ready, 1);
        drain(patt, 1, dc);
        chk("done_seen", dc >= 0, 1);
        chk("beats_total", n_beats, len);
        chk("issues_total", n_issued, len);
        if (exp_done > 0) chk("done_cycle", dc, exp_done);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_ready", bus.cmd_ready, 1);
        chk("idle_busy", bus.busy, 0);
    endtask

    initial begin
        int dc;
        for (int i = 0; i < 2048; i++) ram[i] = exp_byte(11'(i));
        bp_patt = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        //         cv    ca       cl     rdy   en    ra       ov    od     ol    dn    bs    cr
        tbl[0]  = '{1'b1, 11'h010, 12'd4, 1'b1, 1'b0, 11'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 11'h000, 12'd0, 1'b1, 1'b1, 11'h010, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 11'h000, 12'd0, 1'b1, 1'b1, 11'h011, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 11'h000, 12'd0, 1'b1, 1'b1, 11'h012, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 11'h000, 12'd0, 1'b1, 1'b1, 11'h013, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 11'h000, 12'd0, 1'b1, 1'b0, 11'h014, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 11'h000, 12'd0, 1'b1, 1'b0, 11'h014, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 11'h000, 12'd0, 1'b1, 1'b0, 11'h014, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 11'h000, 12'd0, 1'b1, 1'b0, 11'h014, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 11'h055, 12'd0, 1'b1, 1'b0, 11'h014, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 11'h000, 12'd0, 1'b1, 1'b0, 11'h055, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 11'h000, 12'd0, 1'b1, 1'b0, 11'h055, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 11'h000;
        bus.cmd_len   = 12'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_ram_en", bus.ram_en, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            bus.cmd_valid = tbl[i].cv;
            bus.cmd_addr  = tbl[i].ca;
            bus.cmd_len   = tbl[i].cl;
            bus.out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("c%0d_ram_en", i), bus.ram_en, tbl[i].en);
            chk($sformatf("c%0d_ram_addr", i), bus.ram_addr, tbl[i].ra);
            chk($sformatf("c%0d_out_valid", i), bus.out_valid, tbl[i].ov);
            if (tbl[i].ov) chk($sformatf("c%0d_out_data", i), bus.out_data, tbl[i].od);
            chk($sformatf("c%0d_out_last", i), bus.out_last, tbl[i].ol);
            chk($sformatf("c%0d_done", i), bus.done, tbl[i].dn);
            chk($sformatf("c%0d_busy", i), bus.busy, tbl[i].bs);
            chk($sformatf("c%0d_cmd_ready", i), bus.cmd_ready, tbl[i].cr);
        end

        run_burst(11'h7FE, 4, 0, 7);
        run_burst(11'h100, 8, 1, 0);

        // Back-to-back: second command held through a len=3 burst.
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 11'h020;
        bus.cmd_len   = 12'd3;
        bus.out_ready = 1'b1;
        sb_start(11'h020, 3);
        @(negedge clk);
        sample();
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            bus.cmd_addr  = 11'h040;
            bus.cmd_len   = 12'd2;
            bus.cmd_valid = (c <= 7);
            @(negedge clk);
            chk($sformatf("b2b_c%0d_cmd_ready", c), bus.cmd_ready, c == 7);
            chk($sformatf("b2b_c%0d_done", c), bus.done, c == 6);
            chk($sformatf("b2b_c%0d_ram_en", c), bus.ram_en, (c <= 3) || (c == 8));
            if (c == 8) sb_start(11'h040, 2);
            sample();
            if (c == 6) chk("b2b_first_beats", n_beats, 3);
        end
        drain(0, 9, dc);
        chk("b2b_done_cycle", dc, 12);
        chk("b2b_second_beats", n_beats, 2);

        // Reset during beat 2 of a len=6 burst.
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 11'h200;
        bus.cmd_len   = 12'd6;
        bus.out_ready = 1'b1;
        sb_start(11'h200, 6);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            @(negedge clk);
            sample();
        end
        chk("pre_rst_beats", n_beats, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cmd_ready", bus.cmd_ready, 1);
        chk("arst_ram_en", bus.ram_en, 0);
        chk("arst_ram_addr", bus.ram_addr, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_data", bus.out_data, 0);
        chk("arst_out_last", bus.out_last, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("post_rst_valid", bus.out_valid, 0);
            chk("post_rst_done", bus.done, 0);
            chk("post_rst_ram_en", bus.ram_en, 0);
            chk("post_rst_ready", bus.cmd_ready, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
